// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers: default sizes, width function
// and the one-hot address decode also used by the read mux.
package regfile_pkg;

    localparam int unsigned W_DEF    = 8;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned NREG_DEF = 8;

    // Upper bound on registers the decode helper can address.
    localparam int unsigned MAX_NREG = 64;

    // Index width for n items; never narrower than one bit.
    function automatic int unsigned clog2w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One-hot decode of a register index; out-of-range indices yield zero.
    function automatic logic [MAX_NREG-1:0] onehot(input int unsigned idx);
        return MAX_NREG'(1) << idx;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshake plus register-file write port of the write arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned NREG = NREG_DEF
);
    localparam int unsigned AW = clog2w(NREG);
    localparam int unsigned IW = clog2w(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*W-1:0]  req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wr_stall;
    logic [NREG-1:0]    wr_en;
    logic [W-1:0]       wr_data;
    logic [IW-1:0]      wr_src;
    logic               err_oob;

    // Environment side: requesters and the register file's stall input.
    modport master (
        output req_valid, req_addr, req_data, wr_stall,
        input  req_ready, wr_en, wr_data, wr_src, err_oob
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, req_data, wr_stall,
        output req_ready, wr_en, wr_data, wr_src, err_oob
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first valid at or after ptr_i, wrapping.
module rr_pick
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IW  = clog2w(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_oh_c,
    output logic [IW-1:0]   gnt_idx_c,
    output logic            any_c
);

    int unsigned idx_c;
    logic        found_c;

    always_comb begin
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        found_c   = 1'b0;
        idx_c     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = (32'(ptr_i) + k) % NREQ;
            if (!found_c && valid_i[IW'(idx_c)]) begin
                found_c              = 1'b1;
                gnt_oh_c[IW'(idx_c)] = 1'b1;
                gnt_idx_c            = IW'(idx_c);
            end
        end
        any_c = found_c;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port; the accepted
// write is presented on wr_en/wr_data/wr_src one cycle after acceptance.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned W    = W_DEF,
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned NREG = NREG_DEF
) (
    input logic                    clk,
    input logic                    rst,
    regfile_write_arbiter_if.slave bus
);

    localparam int unsigned AW = clog2w(NREG);
    localparam int unsigned IW = clog2w(NREQ);

    logic [NREQ-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;

    logic            open_c;
    logic            accept_c;
    logic            oob_c;
    logic [AW-1:0]   addr_g_c;
    logic [W-1:0]    data_g_c;

    logic [IW-1:0]   rr_ptr_q,  rr_ptr_d;
    logic [NREG-1:0] wr_en_q,   wr_en_d;
    logic [W-1:0]    wr_data_q, wr_data_d;
    logic [IW-1:0]   wr_src_q,  wr_src_d;
    logic            err_oob_q, err_oob_d;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i   (bus.req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_c  (gnt_oh),
        .gnt_idx_c (gnt_idx),
        .any_c     (gnt_any)
    );

    // Grant is only offered when neither reset nor stall blocks the port.
    always_comb begin
        open_c   = !rst && !bus.wr_stall;
        accept_c = gnt_any && open_c;
        addr_g_c = '0;
        data_g_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                addr_g_c = bus.req_addr[i*AW +: AW];
                data_g_c = bus.req_data[i*W +: W];
            end
        end
        oob_c = 32'(addr_g_c) >= NREG;
    end

    // Out-of-range writes are consumed and flagged but never reach a register.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        err_oob_d = err_oob_q;
        if (accept_c) begin
            rr_ptr_d  = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
            wr_data_d = data_g_c;
            wr_src_d  = gnt_idx;
            if (oob_c) begin
                err_oob_d = 1'b1;
            end else begin
                wr_en_d = NREG'(onehot(32'(addr_g_c)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
            err_oob_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
            err_oob_q <= err_oob_d;
        end
    end

    assign bus.req_ready = open_c ? gnt_oh : '0;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_src    = wr_src_q;
    assign bus.err_oob   = err_oob_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter with six registers so out-of-range addresses
// are reachable; a grant-level model predicts ready and the write port.
module tb_regfile_write_arbiter;

    localparam int unsigned W    = 8;
    localparam int unsigned NREQ = 4;
    localparam int unsigned NREG = 6;
    localparam int unsigned AW   = 3;

    logic clk = 1'b0;
    logic rst;

    regfile_write_arbiter_if #(.W(W), .NREQ(NREQ), .NREG(NREG)) bus ();

    regfile_write_arbiter #(.W(W), .NREQ(NREQ), .NREG(NREG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0]   tb_addr [NREQ];
    logic [W-1:0]    tb_data [NREQ];
    logic [NREQ-1:0] obs_ready;

    // Model state: the arbiter described as "who is next in the rotation".
    int              m_ptr;
    int              m_grant;
    logic [NREQ-1:0] m_ready;
    logic [NREG-1:0] m_en;
    logic [W-1:0]    m_data;
    logic [1:0]      m_src;
    logic            m_err;

    // Drive one cycle, capture ready before the edge, advance the model.
    task automatic apply(input logic [NREQ-1:0] v, input logic s, input logic r);
        int a;
        bus.req_valid = v;
        bus.wr_stall  = s;
        rst           = r;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW] = tb_addr[i];
            bus.req_data[i*W +: W]   = tb_data[i];
        end
        #1;
        obs_ready = bus.req_ready;
        m_grant = -1;
        if (!r && !s) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_grant < 0 && v[(m_ptr + k) % NREQ]) m_grant = (m_ptr + k) % NREQ;
            end
        end
        m_ready = (m_grant >= 0) ? NREQ'(1 << m_grant) : '0;
        @(posedge clk);
        #1;
        if (r) begin
            m_ptr = 0; m_en = '0; m_data = '0; m_src = '0; m_err = 1'b0;
        end else if (m_grant >= 0) begin
            a      = int'(tb_addr[m_grant]);
            m_en   = (a < NREG) ? NREG'(1 << a) : '0;
            m_data = tb_data[m_grant];
            m_src  = 2'(m_grant);
            if (a >= NREG) m_err = 1'b1;
            m_ptr  = (m_grant + 1) % NREQ;
        end else begin
            m_en = '0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin tb_addr[i] = AW'(i); tb_data[i] = W'(8'h10 + i); end
        apply(4'b1111, 1'b0, 1'b1);
        apply(4'b1111, 1'b0, 1'b1);
        n_checks++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", obs_ready); end
        n_checks++; if (bus.wr_en !== 6'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        n_checks++; if (bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", bus.wr_data); end
        n_checks++; if (bus.wr_src !== 2'd0) begin n_fail++; $display("FAIL reset_wr_src: got %0d want 0", bus.wr_src); end
        n_checks++; if (bus.err_oob !== 1'b0) begin n_fail++; $display("FAIL reset_err_oob: got %b want 0", bus.err_oob); end
        apply(4'b1111, 1'b0, 1'b0);
        n_checks++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", obs_ready); end
        n_checks++; if (bus.wr_en !== 6'b000001 || bus.wr_src !== 2'd0) begin n_fail++; $display("FAIL reset_first_write: en %b src %0d want 000001 0", bus.wr_en, bus.wr_src); end
    endtask

    task automatic test_single();
        apply(4'b0000, 1'b0, 1'b1);
        tb_addr[0] = 3'd3; tb_data[0] = 8'hA5;
        apply(4'b0001, 1'b0, 1'b0);
        n_checks++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", obs_ready); end
        n_checks++; if (bus.wr_en !== 6'h08) begin n_fail++; $display("FAIL single_wr_en: got %h want 08", bus.wr_en); end
        n_checks++; if (bus.wr_data !== 8'hA5) begin n_fail++; $display("FAIL single_wr_data: got %h want a5", bus.wr_data); end
        n_checks++; if (bus.wr_src !== 2'd0) begin n_fail++; $display("FAIL single_wr_src: got %0d want 0", bus.wr_src); end
        apply(4'b0000, 1'b0, 1'b0);
        n_checks++; if (bus.wr_en !== 6'h00) begin n_fail++; $display("FAIL single_pulse_end: got %h want 00", bus.wr_en); end
        n_checks++; if (bus.wr_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %h want a5", bus.wr_data); end
        // A lone requester wins every cycle wherever the pointer sits.
        tb_addr[2] = 3'd5; tb_data[2] = 8'h77;
        for (int c = 0; c < 3; c++) begin
            apply(4'b0100, 1'b0, 1'b0);
            n_checks++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL lone_ready c%0d: got %b want 0100", c, obs_ready); end
            n_checks++; if (bus.wr_en !== 6'h20) begin n_fail++; $display("FAIL lone_wr_en c%0d: got %h want 20", c, bus.wr_en); end
        end
    endtask

    task automatic test_back_to_back();
        apply(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < NREQ; i++) begin tb_addr[i] = AW'(i); tb_data[i] = W'(8'hC0 + i); end
        for (int c = 0; c < 8; c++) begin
            apply(4'b1111, 1'b0, 1'b0);
            n_checks++; if (obs_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want %b", c, obs_ready, 4'(1 << (c % 4))); end
            n_checks++; if (bus.wr_src !== 2'(c % 4)) begin n_fail++; $display("FAIL b2b_src c%0d: got %0d want %0d", c, bus.wr_src, c % 4); end
            n_checks++; if (bus.wr_en !== 6'(1 << (c % 4))) begin n_fail++; $display("FAIL b2b_wr_en c%0d: got %b want %b", c, bus.wr_en, 6'(1 << (c % 4))); end
            n_checks++; if (bus.wr_data !== W'(8'hC0 + c % 4)) begin n_fail++; $display("FAIL b2b_data c%0d: got %h want %h", c, bus.wr_data, W'(8'hC0 + c % 4)); end
        end
    endtask

    task automatic test_wrap();
        logic [NREQ-1:0] want [3];
        want[0] = 4'b0001; want[1] = 4'b0100; want[2] = 4'b0001;
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b0100, 1'b0, 1'b0);
        n_checks++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup: got %b want 0100", obs_ready); end
        for (int c = 0; c < 3; c++) begin
            apply(4'b0101, 1'b0, 1'b0);
            n_checks++; if (obs_ready !== want[c]) begin n_fail++; $display("FAIL wrap_grant c%0d: got %b want %b", c, obs_ready, want[c]); end
        end
    endtask

    task automatic test_stall();
        apply(4'b0000, 1'b0, 1'b1);
        apply(4'b0010, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            apply(4'b1111, 1'b1, 1'b0);
            n_checks++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready c%0d: got %b want 0000", c, obs_ready); end
            n_checks++; if (bus.wr_en !== 6'b0) begin n_fail++; $display("FAIL stall_wr_en c%0d: got %b want 0", c, bus.wr_en); end
        end
        apply(4'b1111, 1'b0, 1'b0);
        n_checks++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_release: got %b want 0100", obs_ready); end
        n_checks++; if (bus.wr_src !== 2'd2 || bus.wr_en !== m_en) begin n_fail++; $display("FAIL stall_release_write: src %0d en %b want 2 %b", bus.wr_src, bus.wr_en, m_en); end
    endtask

    task automatic test_oob();
        apply(4'b0000, 1'b0, 1'b1);
        tb_addr[0] = 3'd7; tb_data[0] = 8'h3C;
        apply(4'b0001, 1'b0, 1'b0);
        n_checks++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL oob_ready: got %b want 0001", obs_ready); end
        n_checks++; if (bus.wr_en !== 6'b0) begin n_fail++; $display("FAIL oob_wr_en: got %b want 0", bus.wr_en); end
        n_checks++; if (bus.err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_err: got %b want 1", bus.err_oob); end
        tb_addr[1] = 3'd1; tb_data[1] = 8'h11;
        apply(4'b0010, 1'b0, 1'b0);
        n_checks++; if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL oob_next_ready: got %b want 0010", obs_ready); end
        n_checks++; if (bus.err_oob !== 1'b1 || bus.wr_en !== 6'h02) begin n_fail++; $display("FAIL oob_sticky: err %b en %b want 1 000010", bus.err_oob, bus.wr_en); end
        apply(4'b0000, 1'b0, 1'b1);
        n_checks++; if (bus.err_oob !== 1'b0) begin n_fail++; $display("FAIL oob_clear: got %b want 0", bus.err_oob); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] cur;
        logic            s, r;
        int              waits [NREQ];
        cur = '0;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        apply(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!cur[i] && $urandom_range(0, 1) == 1) begin
                    cur[i] = 1'b1; waits[i] = 0;
                    tb_addr[i] = AW'($urandom_range(0, 7));
                    tb_data[i] = W'($urandom);
                end
            end
            s = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 60) == 0);
            apply(cur, s, r);
            n_checks++; if (obs_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, obs_ready, m_ready); end
            n_checks++; if (bus.wr_en !== m_en) begin n_fail++; $display("FAIL rnd_wr_en c%0d: got %b want %b", c, bus.wr_en, m_en); end
            n_checks++; if (bus.wr_data !== m_data || bus.wr_src !== m_src) begin n_fail++; $display("FAIL rnd_data_src c%0d: got %h/%0d want %h/%0d", c, bus.wr_data, bus.wr_src, m_data, m_src); end
            n_checks++; if (bus.err_oob !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, bus.err_oob, m_err); end
            if (r) begin
                for (int i = 0; i < NREQ; i++) waits[i] = 0;
            end else if (m_grant >= 0) begin
                n_checks++; if (waits[m_grant] > NREQ - 1) begin n_fail++; $display("FAIL rnd_fair c%0d: req %0d waited %0d grants", c, m_grant, waits[m_grant]); end
                for (int i = 0; i < NREQ; i++) if (cur[i] && i != m_grant) waits[i]++;
                cur[m_grant] = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.wr_stall  = 1'b0;
        m_ptr = 0; m_grant = -1; m_ready = '0;
        m_en = '0; m_data = '0; m_src = '0; m_err = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_stall();
        test_oob();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter and sequencer for the register file's single write port. It takes write requests (address and data) from up to NREQ requesters over a valid/ready handshake and grants one per cycle. It then drives the register file's per-register write enables (one-hot) and the shared write-data bus one cycle after acceptance. It sits between the requesting datapath units and the register array.

## Interface
- W, 8, data word width; equals the register width.
- NREQ, 4, number of requesters; must be ≥2.
- NREG, 8, number of registers; must be ≥2, need not be a power of two.
- AW, clog2(NREG), address width; derived, not overridden.
- IW, clog2(NREQ), requester index width; derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester write request.
- req_addr  in  NREQ*AW  packed target addresses; requester i at [i*AW +: AW].
- req_data  in  NREQ*W  packed write data; requester i at [i*W +: W].
- req_ready  out  NREQ  per-requester grant; at most one bit high.
- wr_stall  in  1  register file cannot accept a write this cycle.
- wr_en  out  NREG  one-hot write enables to the registers.
- wr_data  out  W  write data to all registers.
- wr_src  out  IW  index of the requester whose write is on wr_en/wr_data.
- err_oob  out  1  sticky flag: an accepted request had addr ≥ NREG.

## Operation
- Grant: a combinational pick among req_valid. The search starts at rr_ptr and wraps modulo NREQ. The first valid requester found is granted g, and only req_ready[g] is set.
- req_ready is all-zero when rst=1 or wr_stall=1.
- A transfer is accepted when req_valid[g] & req_ready[g].
- On acceptance:
  - Next cycle: wr_en = onehot(req_addr[g]), wr_data = req_data[g], wr_src = g.
  - rr_ptr <= (g+1) mod NREQ, wrapping from NREQ-1 to 0.
- No acceptance:
  - Next cycle: wr_en = 0.
  - wr_data and wr_src hold their previous values.
  - rr_ptr is unchanged.
- Out-of-range address (req_addr[g] ≥ NREG): the request is accepted normally (ready, pointer advance). The next cycle has wr_en = 0 and err_oob <= 1. err_oob stays set until rst.
- Fairness: a requester held valid is granted within NREQ accepted transfers. There is no starvation.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not check this.
- The arbiter does not detect same-address collisions. Writes are serialized, so the later accepted write wins.

## Timing
- Reset (rst=1 at an edge): wr_en=0, wr_data=0, wr_src=0, err_oob=0, rr_ptr=0.
  - req_ready=0 combinationally while rst=1.
  - A request presented during reset is not accepted.
- Reset has priority over everything. An acceptance in the cycle rst rises is impossible (ready=0). An output pulse already registered in the previous cycle completes; the reset edge then clears it.
- Latency: acceptance at edge N; wr_en is high for exactly the cycle after edge N. The target register captures on edge N+1.
- Throughput: one write per cycle with back-to-back grants. Grants rotate among all valid requesters.
- wr_stall=1 at an edge: no acceptance, so wr_en=0 in the following cycle. A write already on wr_en in the stall cycle is not repeated or retracted. The register file must assert wr_stall one cycle ahead of when it needs to block.
- With a single valid requester, it is granted every cycle regardless of rr_ptr.

## Structure
- Shared package regfile_pkg holds:
  - the default W, NREG, NREQ constants;
  - the clog2-based width function;
  - the onehot decode function, used by both this block and the register-file read mux.
- One natural sub-module, rr_pick: a pure combinational rotate-priority picker.
  - Inputs: valid vector, start pointer.
  - Outputs: grant one-hot, grant index, any.
  - Reusable for a future read-port arbiter.
- Top level holds rr_ptr, the output register stage (wr_en, wr_data, wr_src) and err_oob.

## Test plan
- Reset, then req_valid=0001, addr0=3, data0=0xA5 → req_ready=0001 the same cycle. Next cycle: wr_en=0x08, wr_data=0xA5, wr_src=0. Following cycle: wr_en=0.
- All four valid continuously, rr_ptr=0 → grant order 0,1,2,3,0,… and wr_src follows that order. wr_en is high every cycle for 8 cycles.
- rr_ptr=3 (after granting 2), req_valid=0101 → grant 0 (wrap past 3 to 0), then 2, then 0.
- wr_stall=1 for 3 cycles with req_valid=1111 → req_ready=0000 throughout. wr_en is 0 in the 3 cycles after the stall edges. The first grant after release goes to the requester at rr_ptr.
- NREG=6, request addr=7, data=0x3C → accepted, next cycle wr_en=0 and err_oob=1. err_oob stays 1 through further valid writes until rst=1 clears it.
- rst asserted in the same cycle as req_valid=1111 → req_ready=0. After reset: all outputs 0, rr_ptr=0, and the first grant goes to requester 0.
